// File: rtl/pool_stride_sel.sv
// pool_stride_sel
//   Follows the binary pooling line-buffer stage. For every accepted pixel it
//   tracks the (row, col) position in the image. It keeps only the outputs
//   whose position closes a full KERNEL_DIM x KERNEL_DIM window and is
//   stride-aligned. Kept outputs go into a small FIFO and are handed to the
//   next layer with valid/ready. The last kept output of a frame is marked.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   i_clear       synchronous frame abort: zero position, flush FIFO
//   i_valid       pooled pixel present
//   i_data        pooled bits for the window ending at the current pixel
//   o_in_ready    block can accept a pixel (FIFO not full)
//   o_valid       FIFO head valid
//   o_data        FIFO head data (zero when empty)
//   o_last        FIFO head is the last kept output of its frame
//   i_ready       downstream accepts the head
//   o_frame_cnt   completed-frame counter, 16 bits; only present when
//                 POOL_STRIDE_SEL_FRAME_CNT_EN is defined
//
// Optional feature macro: POOL_STRIDE_SEL_FRAME_CNT_EN

module pool_stride_sel #(
  parameter int IMG_DIM        = 28,
  parameter int KERNEL_DIM     = 2,
  parameter int STRIDE         = 2,
  parameter int INPUT_CHANNELS = 1,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_clear,
  input  logic                      i_valid,
  input  logic [INPUT_CHANNELS-1:0] i_data,
  output logic                      o_in_ready,
  output logic                      o_valid,
  output logic [INPUT_CHANNELS-1:0] o_data,
  output logic                      o_last,
  input  logic                      i_ready
`ifdef POOL_STRIDE_SEL_FRAME_CNT_EN
  ,
  output logic [15:0]               o_frame_cnt
`endif
);

  localparam int CW      = (IMG_DIM > 1) ? $clog2(IMG_DIM) : 1;
  localparam int PW      = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int OUT_DIM = (IMG_DIM - KERNEL_DIM) / STRIDE + 1;

  localparam logic [CW-1:0] POS_END  = CW'(IMG_DIM - 1);
  localparam logic [CW-1:0] POS_K    = CW'(KERNEL_DIM - 1);
  localparam logic [CW-1:0] POS_LAST = CW'(KERNEL_DIM - 1 + (OUT_DIM - 1) * STRIDE);
  localparam logic [PW-1:0] PH_MAX   = PW'(STRIDE - 1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [INPUT_CHANNELS-1:0] data;
    logic                      last;
  } entry_t;

  logic [CW-1:0] col_q, col_d, row_q, row_d;
  logic [PW-1:0] col_ph_q, col_ph_d, row_ph_q, row_ph_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  entry_t        mem_q [FIFO_DEPTH];
  entry_t        head;

  logic          accept, pop, push, keep, is_last;
  logic          col_wrap, frame_end;
  logic [CW-1:0] col_nxt, row_nxt;

  // Phase of a position relative to the first full window, modulo STRIDE.
  // It restarts at 0 when the position reaches KERNEL_DIM-1. Before that
  // point its value is ignored.
  function automatic logic [PW-1:0] next_phase(input logic [CW-1:0] nxt_pos,
                                               input logic [PW-1:0] ph);
    if (nxt_pos == POS_K)  return '0;
    else if (ph == PH_MAX) return '0;
    else                   return ph + 1'b1;
  endfunction

  // No pop bypass: readiness depends only on the registered count.
  assign o_in_ready = (count_q < CNT_FULL);
  assign o_valid    = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];
  // Gate the head with o_valid. The outputs are then zero whenever the FIFO
  // is empty, including immediately on asynchronous reset.
  assign o_data     = o_valid ? head.data : '0;
  assign o_last     = o_valid & head.last;

  assign accept     = i_valid & o_in_ready;
  assign pop        = o_valid & i_ready;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    col_d     = col_q;
    row_d     = row_q;
    col_ph_d  = col_ph_q;
    row_ph_d  = row_ph_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;

    col_wrap  = (col_q == POS_END);
    frame_end = col_wrap && (row_q == POS_END);
    keep      = (row_q >= POS_K) && (col_q >= POS_K) &&
                (row_ph_q == '0) && (col_ph_q == '0);
    is_last   = (row_q == POS_LAST) && (col_q == POS_LAST);
    push      = accept & keep;
    col_nxt   = col_wrap ? '0 : col_q + 1'b1;
    row_nxt   = frame_end ? '0 : row_q + 1'b1;

    if (i_clear) begin
      col_d    = '0;
      row_d    = '0;
      col_ph_d = '0;
      row_ph_d = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) begin
        col_d    = col_nxt;
        col_ph_d = next_phase(col_nxt, col_ph_q);
        if (col_wrap) begin
          row_d    = row_nxt;
          row_ph_d = next_phase(row_nxt, row_ph_q);
        end
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!rst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      col_ph_q <= '0;
      row_ph_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      col_ph_q <= col_ph_d;
      row_ph_q <= row_ph_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: FIFO storage has no reset. Entries are read only when count_q says
  // they are valid, so resetting the array would cost logic for no benefit.
  always_ff @(posedge clk) begin
    if (push && !i_clear) mem_q[wr_ptr_q] <= '{data: i_data, last: is_last};
  end

`ifdef POOL_STRIDE_SEL_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (i_clear)                  frame_cnt_d = '0;
    else if (accept && frame_end) frame_cnt_d = frame_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else        frame_cnt_q <= frame_cnt_d;
  end

  assign o_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_pool_stride_sel.sv
// Bench for pool_stride_sel. Two instances are used:
//   A: IMG_DIM=6, KERNEL_DIM=2, STRIDE=2, FIFO_DEPTH=4
//   B: IMG_DIM=5, KERNEL_DIM=3, STRIDE=1, FIFO_DEPTH=4
// Each instance has a queue-based reference model. It works from plain
// row/col arithmetic and checks that instance's outputs on every falling edge.
// Directed phases add hand-computed expectations for counts and sequences.

module tb_pool_stride_sel;

  localparam int A_IMG = 6, A_K = 2, A_S = 2, A_DEPTH = 4;
  localparam int B_IMG = 5, B_K = 3, B_S = 1, B_DEPTH = 4;

  typedef struct { bit d; bit l; } ent_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       a_clear = 0, a_valid = 0, a_ready = 0;
  logic [0:0] a_data = '0;
  logic       a_in_ready, a_o_valid, a_o_last;
  logic [0:0] a_o_data;
  logic       b_clear = 0, b_valid = 0, b_ready = 0;
  logic [0:0] b_data = '0;
  logic       b_in_ready, b_o_valid, b_o_last;
  logic [0:0] b_o_data;
`ifdef POOL_STRIDE_SEL_FRAME_CNT_EN
  logic [15:0] a_frame_cnt, b_frame_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pool_stride_sel #(.IMG_DIM(A_IMG), .KERNEL_DIM(A_K), .STRIDE(A_S),
                    .INPUT_CHANNELS(1), .FIFO_DEPTH(A_DEPTH)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_clear(a_clear), .i_valid(a_valid),
    .i_data(a_data), .o_in_ready(a_in_ready), .o_valid(a_o_valid),
    .o_data(a_o_data), .o_last(a_o_last), .i_ready(a_ready)
`ifdef POOL_STRIDE_SEL_FRAME_CNT_EN
    , .o_frame_cnt(a_frame_cnt)
`endif
  );

  pool_stride_sel #(.IMG_DIM(B_IMG), .KERNEL_DIM(B_K), .STRIDE(B_S),
                    .INPUT_CHANNELS(1), .FIFO_DEPTH(B_DEPTH)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_clear(b_clear), .i_valid(b_valid),
    .i_data(b_data), .o_in_ready(b_in_ready), .o_valid(b_o_valid),
    .o_data(b_o_data), .o_last(b_o_last), .i_ready(b_ready)
`ifdef POOL_STRIDE_SEL_FRAME_CNT_EN
    , .o_frame_cnt(b_frame_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_keep(input int r, input int c, input int k, input int s);
    return (r >= k-1) && (c >= k-1) && ((r-(k-1)) % s == 0) && ((c-(k-1)) % s == 0);
  endfunction

  function automatic bit is_last(input int r, input int c, input int img, input int k, input int s);
    int p;
    p = (k-1) + ((img-k)/s) * s;
    return (r == p) && (c == p);
  endfunction

  // ---------------- reference models ----------------
  ent_t        qa[$], qb[$];
  int          ra = 0, ca = 0, rb = 0, cb = 0, acc_a = 0;
  logic [15:0] fa = 0, fb = 0;
  logic [31:0] la_d = 0, la_l = 0, lb_d = 0, lb_l = 0;
  int          la_n = 0, lb_n = 0;

  always @(negedge clk) begin : model_a
    ent_t e;
    bit   can_acc;
    if (!rst_n) begin
      qa.delete(); ra = 0; ca = 0; fa = 0;
      check("a_rst_valid", 32'(a_o_valid), 0);
      check("a_rst_data",  32'(a_o_data),  0);
      check("a_rst_last",  32'(a_o_last),  0);
    end else begin
      can_acc = (qa.size() < A_DEPTH);
      check("a_valid",    32'(a_o_valid),  32'(qa.size() != 0));
      check("a_in_ready", 32'(a_in_ready), 32'(can_acc));
      if (qa.size() != 0) begin
        check("a_data", 32'(a_o_data), 32'(qa[0].d));
        check("a_last", 32'(a_o_last), 32'(qa[0].l));
      end
`ifdef POOL_STRIDE_SEL_FRAME_CNT_EN
      check("a_frame_cnt", 32'(a_frame_cnt), 32'(fa));
`endif
      if (a_clear) begin
        qa.delete(); ra = 0; ca = 0; fa = 0;
      end else begin
        if (qa.size() != 0 && a_ready) begin
          if (la_n < 32) begin la_d[la_n] = qa[0].d; la_l[la_n] = qa[0].l; end
          la_n++;
          void'(qa.pop_front());
        end
        if (a_valid && can_acc) begin
          if (is_keep(ra, ca, A_K, A_S)) begin
            e.d = a_data[0]; e.l = is_last(ra, ca, A_IMG, A_K, A_S);
            qa.push_back(e);
          end
          acc_a++;
          if (ra == A_IMG-1 && ca == A_IMG-1) fa = fa + 16'd1;
          ca++;
          if (ca == A_IMG) begin ca = 0; ra++; if (ra == A_IMG) ra = 0; end
        end
      end
    end
  end

  always @(negedge clk) begin : model_b
    ent_t e;
    bit   can_acc;
    if (!rst_n) begin
      qb.delete(); rb = 0; cb = 0; fb = 0;
      check("b_rst_valid", 32'(b_o_valid), 0);
    end else begin
      can_acc = (qb.size() < B_DEPTH);
      check("b_valid",    32'(b_o_valid),  32'(qb.size() != 0));
      check("b_in_ready", 32'(b_in_ready), 32'(can_acc));
      if (qb.size() != 0) begin
        check("b_data", 32'(b_o_data), 32'(qb[0].d));
        check("b_last", 32'(b_o_last), 32'(qb[0].l));
      end
`ifdef POOL_STRIDE_SEL_FRAME_CNT_EN
      check("b_frame_cnt", 32'(b_frame_cnt), 32'(fb));
`endif
      if (b_clear) begin
        qb.delete(); rb = 0; cb = 0; fb = 0;
      end else begin
        if (qb.size() != 0 && b_ready) begin
          if (lb_n < 32) begin lb_d[lb_n] = qb[0].d; lb_l[lb_n] = qb[0].l; end
          lb_n++;
          void'(qb.pop_front());
        end
        if (b_valid && can_acc) begin
          if (is_keep(rb, cb, B_K, B_S)) begin
            e.d = b_data[0]; e.l = is_last(rb, cb, B_IMG, B_K, B_S);
            qb.push_back(e);
          end
          if (rb == B_IMG-1 && cb == B_IMG-1) fb = fb + 16'd1;
          cb++;
          if (cb == B_IMG) begin cb = 0; rb++; if (rb == B_IMG) rb = 0; end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_a(input bit d);
    bit ok;
    ok = 0;
    a_valid = 1; a_data = d;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = a_in_ready;
    end
    check("a_send_wait", 32'(ok), 1);
    @(posedge clk); #1;
    a_valid = 0;
  endtask

  task automatic send_b(input bit d);
    bit ok;
    ok = 0;
    b_valid = 1; b_data = d;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = b_in_ready;
    end
    check("b_send_wait", 32'(ok), 1);
    @(posedge clk); #1;
    b_valid = 0;
  endtask

  task automatic drain_a();
    bit done;
    done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = !a_o_valid;
    end
    check("a_drain", 32'(done), 1);
    @(posedge clk); #1;
  endtask

  task automatic drain_b();
    bit done;
    done = 0;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      done = !b_o_valid;
    end
    check("b_drain", 32'(done), 1);
    @(posedge clk); #1;
  endtask

  task automatic clear_logs();
    la_d = 0; la_l = 0; la_n = 0;
    lb_d = 0; lb_l = 0; lb_n = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed phases ----------------
  initial begin
    int acc_base;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("rst_in_ready", 32'(a_in_ready), 1);
    check("rst_valid",    32'(a_o_valid),  0);
    @(posedge clk); #1;

    // Two back-to-back frames on A, data = LSB of row*6+col, downstream always ready.
    a_ready = 1;
    clear_logs();
    for (int i = 0; i < 2 * A_IMG * A_IMG; i++) send_a(1'((i % 36) & 1));
    drain_a();
    check("a_2f_count", 32'(la_n), 18);
    check("a_2f_data",  la_d, 32'h3FFFF);
    check("a_2f_last",  la_l, 32'h20100);
`ifdef POOL_STRIDE_SEL_FRAME_CNT_EN
    check("a_2f_frame_cnt", 32'(a_frame_cnt), 2);
`endif

    // Backpressure: downstream stalled, the FIFO fills at the 4th kept pixel (index 19).
    a_ready = 0;
    clear_logs();
    acc_base = acc_a;
    for (int i = 0; i < 20; i++) send_a(1'(i & 1));
    a_valid = 1; a_data = 1'(20 & 1);
    repeat (5) @(negedge clk);
    check("a_stall_ready", 32'(a_in_ready), 0);
    check("a_stall_acc",   32'(acc_a - acc_base), 20);
    @(posedge clk); #1;
    a_ready = 1;
    for (int i = 20; i < 36; i++) send_a(1'(i & 1));
    drain_a();
    check("a_stall_count", 32'(la_n), 9);
    check("a_stall_data",  la_d, 32'h1FF);
    check("a_stall_last",  la_l, 32'h100);

    // Clear after 20 pixels with two entries (pixels 11 and 19) buffered.
    a_ready = 1;
    for (int i = 0; i < 10; i++) send_a(1'(i & 1));
    repeat (3) @(posedge clk);
    #1 a_ready = 0;
    for (int i = 10; i < 20; i++) send_a(1'(i & 1));
    @(negedge clk);
    check("a_pre_clr_valid", 32'(a_o_valid), 1);
    @(posedge clk); #1;
    a_clear = 1; a_valid = 1; a_data = 1; a_ready = 1;
    @(posedge clk); #1;
    a_clear = 0; a_valid = 0;
    @(negedge clk);
    check("a_clr_valid", 32'(a_o_valid), 0);
    @(posedge clk); #1;
    clear_logs();
    for (int i = 0; i < 36; i++) send_a(1'(i & 1));
    drain_a();
    check("a_clr_count", 32'(la_n), 9);
    check("a_clr_last",  la_l, 32'h100);

    // Random data with random downstream readiness; the model checks every cycle.
    clear_logs();
    for (int i = 0; i < 36; i++) begin
      a_ready = 1'($urandom_range(0, 1));
      send_a(1'($urandom_range(0, 1)));
    end
    a_ready = 1;
    drain_a();
    check("a_rand_count", 32'(la_n), 9);
    check("a_rand_last",  la_l, 32'h100);

    // Instance B: 3x3 window, stride 1, 5x5 image; data = LSB of row*5+col.
    b_ready = 1;
    clear_logs();
    for (int i = 0; i < B_IMG * B_IMG; i++) send_b(1'(i & 1));
    drain_b();
    check("b_count", 32'(lb_n), 9);
    check("b_data",  lb_d, 32'h0AA);
    check("b_last",  lb_l, 32'h100);

    // Asynchronous reset mid-frame while the head is valid (pixel 7 has data 1).
    a_ready = 0;
    for (int i = 0; i < 10; i++) send_a(1'(i & 1));
    @(negedge clk);
    check("a_pre_rst_valid", 32'(a_o_valid), 1);
    check("a_pre_rst_data",  32'(a_o_data),  1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    check("a_async_valid", 32'(a_o_valid), 0);
    check("a_async_data",  32'(a_o_data),  0);
    check("a_async_last",  32'(a_o_last),  0);
    @(posedge clk); #1;
    rst_n = 1;
    a_ready = 1;
    clear_logs();
    for (int i = 0; i < 36; i++) send_a(1'(i & 1));
    drain_a();
    check("a_post_rst_count", 32'(la_n), 9);
    check("a_post_rst_data",  la_d, 32'h1FF);
    check("a_post_rst_last",  la_l, 32'h100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_stride_sel.md
Name: pool_stride_sel

Overview:
- Sits directly downstream of the binary pooling line-buffer stage.
- That stage emits one pooled bit per channel for every accepted input pixel. The result is meaningful only where a full KERNEL_DIM×KERNEL_DIM window exists and the position is stride-aligned.
- This block tracks row/column position over the image stream and keeps only the stride-aligned window outputs.
- Kept outputs are buffered in a small FIFO and presented to the next layer with a valid/ready handshake, frame-end marker and input backpressure.

Parameters:
- IMG_DIM, 28, input image width and height in pixels
- KERNEL_DIM, 2, pooling window size
- STRIDE, 2, pooling stride (both axes)
- INPUT_CHANNELS, 1, channels per pixel (bits per beat)
- FIFO_DEPTH, 4, output FIFO entries, power of 2, ≥2

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- i_clear  input  1  synchronous frame abort: zero counters, flush FIFO
- i_valid  input  1  pooled pixel present (driven alongside the pooling stage's write enable)
- i_data  input  INPUT_CHANNELS  pooled bits for the window ending at the current pixel
- o_in_ready  output  1  block can accept a pixel
- o_valid  output  1  FIFO head valid
- o_data  output  INPUT_CHANNELS  FIFO head data
- o_last  output  1  FIFO head is the last kept output of its frame
- i_ready  input  1  downstream accepts head

Behaviour:
- Reset (rst_n=0, asynchronous): col=0, row=0, FIFO empty, o_valid=0, o_data=0, o_last=0. o_in_ready=1 after release.
- Accept: i_valid & o_in_ready. Counters advance only on accept.
- Counter update on accept: col increments; col==IMG_DIM-1 wraps to 0 and increments row. row==IMG_DIM-1 with col==IMG_DIM-1 wraps both to 0 (frame end).
- Keep condition, evaluated on pre-increment row/col of the accepted pixel: row≥KERNEL_DIM-1, col≥KERNEL_DIM-1, (row-(KERNEL_DIM-1)) mod STRIDE==0 and (col-(KERNEL_DIM-1)) mod STRIDE==0.
- Modulo tracking: use phase counters (0..STRIDE-1) reset at position KERNEL_DIM-1. No dividers.
- Kept pixels push {i_data, last} into the FIFO.
- last=1 for the kept pixel at row=col=KERNEL_DIM-1+(OUT_DIM-1)*STRIDE, where OUT_DIM=(IMG_DIM-KERNEL_DIM)/STRIDE+1 (integer division).
- Discarded pixels: counters advance, FIFO untouched.
- Defaults: OUT_DIM=14, 196 kept outputs per frame.
- o_in_ready = (fifo_count < FIFO_DEPTH). Driven combinationally from registered count; no pop-bypass. A full FIFO stalls all input, kept or discarded.
- Output side: o_valid = (fifo_count != 0). o_data/o_last show the head entry. Pop on o_valid & i_ready.
- Simultaneous push and pop: count unchanged, data ordering preserved. Push into an empty FIFO is visible on o_valid the next cycle (1-cycle latency).
- Head stability: o_data and o_last hold while o_valid & !i_ready.
- i_clear (synchronous): zero counters and phases, empty FIFO. Any same-cycle accept or pop is ignored. o_valid=0 next cycle.
- Reset mid-frame: identical to power-on; the partial frame is lost.
- FIFO pointers: log2(FIFO_DEPTH) bits wrapping naturally; count has one extra bit.

Optional Feature:
- Macro: POOL_STRIDE_SEL_FRAME_CNT_EN.
- Defined:
  - Adds output port o_frame_cnt, 16 bits, reset to 0.
  - Increments when the frame-end pixel is accepted; wraps at 16'hFFFF.
  - i_clear zeroes it.
- Undefined: the port and register do not exist; behaviour is otherwise identical.

Test Plan:
- Params IMG_DIM=6, KERNEL_DIM=2, STRIDE=2, i_ready=1. Stream 36 pixels with i_data=row*6+col LSB:
  - 9 outputs, taken at (row,col) ∈ {1,3,5}².
  - o_last=1 only on (5,5).
  - Output bits match the LSBs of 7,9,11,19,21,23,31,33,35.
- Same params, i_ready=0, FIFO_DEPTH=4:
  - o_in_ready drops the cycle after the 4th kept push; input stalls.
  - Raise i_ready: all 9 outputs arrive in order, none lost or duplicated.
- KERNEL_DIM=3, STRIDE=1, IMG_DIM=5: 9 outputs at rows/cols 2..4; o_last on (4,4).
- Two back-to-back frames: counters wrap; second frame yields an identical 9-output pattern. With POOL_STRIDE_SEL_FRAME_CNT_EN, o_frame_cnt reads 2.
- Assert i_clear after 20 pixels with 2 entries buffered: o_valid=0 next cycle. A fresh 36-pixel frame gives exactly 9 outputs.
- Assert rst_n=0 asynchronously mid-frame while o_valid=1: o_valid, o_data and o_last go to 0 immediately, before the next clk edge.
